// File: rtl/line_fetch_sched.sv
// Line-buffer refill scheduler: issues DDR2 read bursts one video line at a
// time, paced by display line requests, and counts completed frames.
module line_fetch_sched #(
   parameter int ADDR_W          = 24,
   parameter int LINES_PER_FRAME = 480,
   parameter int BURSTS_PER_LINE = 20,
   parameter int BURST_STEP      = 32,
   parameter int LINE_STRIDE     = 1024,
   parameter int FRAME_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_go,
   input  logic               line_req,
   output logic               rd_xfr_en,
   output logic [ADDR_W-1:0]  rd_mem_addr,
   input  logic               rd_xfr_ack,
   input  logic               rd_burst_done,
   output logic               line_ready,
   output logic [FRAME_W-1:0] screen_cnt,
   output logic               busy,
   output logic               ovf_err
);

   localparam int LINE_W  = $clog2(LINES_PER_FRAME);
   localparam int BURST_W = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;

   localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(LINES_PER_FRAME - 1);
   localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(BURSTS_PER_LINE - 1);
   localparam logic [ADDR_W-1:0]  STEP       = ADDR_W'(BURST_STEP);
   localparam logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(LINE_STRIDE);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_DONE,
      WAIT_LINE
   } state_t;

   state_t               state_reg,      state_next;
   logic [LINE_W-1:0]    line_idx_reg,   line_idx_next;
   logic [BURST_W-1:0]   burst_idx_reg,  burst_idx_next;
   logic [ADDR_W-1:0]    line_base_reg,  line_base_next;
   logic [ADDR_W-1:0]    burst_off_reg,  burst_off_next;
   logic                 pend_reg,       pend_next;
   logic                 ovf_reg,        ovf_next;
   logic [FRAME_W-1:0]   screen_cnt_reg, screen_cnt_next;
   logic                 line_ready_reg, line_ready_next;
   logic                 xfr_en_reg;
   logic [ADDR_W-1:0]    addr_reg;
   logic                 busy_reg;

   // An ack only counts once the request is actually visible to the manager.
   logic ack_take;
   assign ack_take = (state_reg == REQ) && xfr_en_reg && rd_xfr_ack;

   always_comb begin
      state_next      = state_reg;
      line_idx_next   = line_idx_reg;
      burst_idx_next  = burst_idx_reg;
      line_base_next  = line_base_reg;
      burst_off_next  = burst_off_reg;
      pend_next       = pend_reg;
      ovf_next        = ovf_reg;
      screen_cnt_next = screen_cnt_reg;
      line_ready_next = 1'b0;

      // Early requests during a line are remembered once; a second one is an overrun.
      if (((state_reg == REQ) || (state_reg == WAIT_DONE)) && line_req) begin
         if (pend_reg) begin
            ovf_next = 1'b1;
         end else begin
            pend_next = 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (rd_go) begin
               line_idx_next  = '0;
               burst_idx_next = '0;
               line_base_next = '0;
               burst_off_next = '0;
               pend_next      = 1'b0;
               state_next     = REQ;
            end
         end
         REQ: begin
            if (ack_take) begin
               state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (rd_burst_done) begin
               if (burst_idx_reg != LAST_BURST) begin
                  burst_idx_next = burst_idx_reg + BURST_W'(1);
                  burst_off_next = burst_off_reg + STEP;
                  state_next     = REQ;
               end else begin
                  burst_idx_next  = '0;
                  burst_off_next  = '0;
                  line_ready_next = 1'b1;
                  state_next      = WAIT_LINE;
               end
            end
         end
         WAIT_LINE: begin
            if (line_req || pend_reg) begin
               pend_next  = 1'b0;
               state_next = REQ;
               if (line_idx_reg == LAST_LINE) begin
                  line_idx_next   = '0;
                  line_base_next  = '0;
                  screen_cnt_next = screen_cnt_reg + FRAME_W'(1);
               end else begin
                  line_idx_next  = line_idx_reg + LINE_W'(1);
                  line_base_next = line_base_reg + STRIDE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         line_idx_reg   <= '0;
         burst_idx_reg  <= '0;
         line_base_reg  <= '0;
         burst_off_reg  <= '0;
         pend_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         screen_cnt_reg <= '0;
         line_ready_reg <= 1'b0;
         xfr_en_reg     <= 1'b0;
         addr_reg       <= '0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         line_idx_reg   <= line_idx_next;
         burst_idx_reg  <= burst_idx_next;
         line_base_reg  <= line_base_next;
         burst_off_reg  <= burst_off_next;
         pend_reg       <= pend_next;
         ovf_reg        <= ovf_next;
         screen_cnt_reg <= screen_cnt_next;
         line_ready_reg <= line_ready_next;
         // Request outputs trail the state by one register so the address is settled.
         xfr_en_reg     <= (state_reg == REQ) && !ack_take;
         addr_reg       <= line_base_reg + burst_off_reg;
         busy_reg       <= (state_reg != IDLE);
      end
   end

   assign rd_xfr_en   = xfr_en_reg;
   assign rd_mem_addr = addr_reg;
   assign line_ready  = line_ready_reg;
   assign screen_cnt  = screen_cnt_reg;
   assign busy        = busy_reg;
   assign ovf_err     = ovf_reg;

endmodule

// File: doc/line_fetch_sched.md
# line_fetch_sched

Schedules DDR2 read bursts that refill the display line buffer, one video line at a time. After a start pulse it fetches line 0, then fetches each following line when the display side asks for it. Each line is fetched as a series of burst requests handed to the DDR2 manager's read port. The block also counts completed frames. It sits between the display timing/line-buffer logic and the DDR2 manager read-request interface.

## Interface
Parameters:
- ADDR_W, 24: width of the memory word address.
- LINES_PER_FRAME, 480: number of lines per frame (>=2).
- BURSTS_PER_LINE, 20: number of read bursts per line (>=1).
- BURST_STEP, 32: address increment between bursts within a line.
- LINE_STRIDE, 1024: address increment between line bases.
- FRAME_W, 16: width of the frame counter.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- rd_go, in, 1: start pulse; honoured only in IDLE.
- line_req, in, 1: one-cycle pulse from the display asking for the next line.
- rd_xfr_en, out, 1: burst read request, level.
- rd_mem_addr, out, ADDR_W: burst start address; valid while rd_xfr_en=1.
- rd_xfr_ack, in, 1: the manager accepted the current request.
- rd_burst_done, in, 1: the burst's data has been written into the line buffer.
- line_ready, out, 1: one-cycle pulse when every burst of a line is done.
- screen_cnt, out, FRAME_W: count of completed frames.
- busy, out, 1: 1 in any state except IDLE.
- ovf_err, out, 1: sticky flag for a line-request overrun.

## Operation
- The design has one clock. Reset is synchronous and active-high.
- States: IDLE, REQ, WAIT_DONE, WAIT_LINE.
- Internal registers:
  - line_idx, 0..LINES_PER_FRAME-1.
  - burst_idx, 0..BURSTS_PER_LINE-1.
  - line_base and burst_off, both ADDR_W wide and kept as running sums.
  - pend, a 1-deep pending flag for line_req.
- Address: rd_mem_addr = line_base + burst_off. The sum is truncated modulo 2^ADDR_W and uses no multiplier.
- IDLE:
  - On rd_go, clear line_idx, burst_idx, line_base, burst_off and pend, then go to REQ.
  - line_req in IDLE is ignored.
- REQ:
  - rd_xfr_en=1 and rd_mem_addr holds steady.
  - On rd_xfr_ack, go to WAIT_DONE.
- WAIT_DONE, on rd_burst_done:
  - If burst_idx < BURSTS_PER_LINE-1: burst_idx+=1, burst_off+=BURST_STEP, go to REQ.
  - Otherwise: burst_idx=0, burst_off=0, pulse line_ready, go to WAIT_LINE.
- WAIT_LINE, on line_req or with pend=1: clear pend, advance the line and go to REQ.
- Line advance:
  - If line_idx == LINES_PER_FRAME-1: line_idx=0, line_base=0, screen_cnt+=1 (wraps modulo 2^FRAME_W).
  - Otherwise: line_idx+=1, line_base+=LINE_STRIDE.
- line_req while in REQ or WAIT_DONE:
  - Sets pend.
  - If pend is already 1, it also sets ovf_err. The request is dropped and pend stays 1.
- ovf_err clears only on rst.
- rd_go outside IDLE is ignored.
- rd_burst_done outside WAIT_DONE is ignored.
- rd_xfr_ack outside REQ is ignored.

## Timing
- Reset values: rd_xfr_en=0, rd_mem_addr=0, line_ready=0, screen_cnt=0, busy=0, ovf_err=0, state=IDLE.
- rst asserted mid-operation aborts any burst in flight. Nothing is retried and all outputs take their reset values on the next edge.
- All outputs are registered.
- rd_go sampled at edge N gives rd_xfr_en=1 and busy=1 after edge N+1 (1-cycle latency). rd_mem_addr is valid in the same cycle.
- rd_xfr_ack sampled high at edge N drops rd_xfr_en after that edge. The request is held indefinitely until ack arrives.
- rd_burst_done at edge N (not the last burst): the next request is asserted after edge N+1, with the address already advanced.
- Last rd_burst_done at edge N: line_ready=1 for exactly the cycle after edge N.
- line_req in WAIT_LINE at edge N: rd_xfr_en=1 after edge N+1.
- pend=1 on entering WAIT_LINE: exactly one cycle is spent in WAIT_LINE, then REQ.
- line_req arriving in the same cycle as the last rd_burst_done counts as a request during WAIT_DONE. It sets pend, so the next line is fetched without waiting.

## Test plan
- **Start fetch:** reset, then rd_go at cycle 10; the bench acks every request one cycle later and returns done two cycles after ack.
  - Expect rd_xfr_en high at cycle 11 with addr 0x000000.
  - The second request has addr 0x000020 and the 20th has addr 0x000260.
  - line_ready pulses once; busy=1 throughout.
- **Line advance:** after line 0 completes, pulse line_req.
  - Line 1 requests run 0x000400, 0x000420, …
  - screen_cnt stays 0.
- **Frame wrap:** run 480 lines.
  - After line 479 (base 0x077C00), the next line_req fetches addr 0x000000.
  - screen_cnt=1 at that advance.
  - Run 2 full frames and check screen_cnt=2.
- **Early/overrun request:**
  - One line_req mid-line: pend is set, WAIT_LINE lasts exactly one cycle, the next line starts with no further line_req, and ovf_err stays 0.
  - Two line_req pulses mid-line: ovf_err=1 and sticky, and only one extra line is fetched.
- **Stalled ack:** hold rd_xfr_ack low for 50 cycles.
  - rd_xfr_en and rd_mem_addr stay stable.
  - Stray rd_burst_done pulses and a second rd_go cause no state change.
- **Reset mid-burst:** assert rst while in WAIT_DONE.
  - All outputs are 0 after the next edge.
  - A subsequent rd_go restarts at addr 0x000000.
